hazard_stall_ctrl: RTL and testbench

- Hazard/stall controller for the 16-bit pipeline.
- Directly upstream of the ID-stage stall mux: its `stall` output is that mux's select, choosing the bubble word over the decoded control word.
- Detects load-use hazards between ID and EX and holds IF/ID for a configurable load latency.
- Sequences IF/ID flushes after a taken branch and keeps a saturating count of stall cycles for performance debug.

---
 rtl/hazard_stall_ctrl.sv | 108 ++++++++++
 tb/tb_hazard_stall_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Load-use hazard detection and IF/ID stall/flush sequencing for the
// 16-bit pipeline, with a saturating stall-cycle counter.
module hazard_stall_ctrl #(
  parameter int REG_W     = 3,
  parameter int MEM_LAT   = 2,
  parameter int FLUSH_LAT = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             branch_taken,
  output logic             stall,
  output logic             pc_write_en,
  output logic             ifid_write_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             busy,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [2:0] MEM_REM = 3'(MEM_LAT - 1);
  localparam logic [2:0] FL_REM  = 3'(FLUSH_LAT - 1);

  state_t           state_q;
  logic [2:0]       rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic             hazard;
  logic             stall_c;
  logic             flush_c;

  assign hazard = ex_mem_read & (ex_rd != '0) &
                  ((id_use_rs1 & (id_rs1 == ex_rd)) |
                   (id_use_rs2 & (id_rs2 == ex_rd)));

  // Branch wins over a hazard in the same IDLE cycle.
  always_comb begin
    stall_c = 1'b0;
    flush_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (branch_taken)
          flush_c = 1'b1;
        else if (hazard)
          stall_c = 1'b1;
      end
      STALL:   stall_c = 1'b1;
      FLUSH:   flush_c = 1'b1;
      default: ;
    endcase
  end

  // Reset forces the pipeline-facing controls to their run values.
  assign stall         = rst_n & stall_c;
  assign ifid_flush    = rst_n & flush_c;
  assign idex_bubble   = stall | ifid_flush;
  assign pc_write_en   = ~stall;
  assign ifid_write_en = ~stall;
  assign busy          = rst_n & (state_q != IDLE);
  assign stall_count   = rst_n ? cnt_q : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      if (stall_c && !(&cnt_q))
        cnt_q <= cnt_q + 1'b1;
      unique case (state_q)
        IDLE: begin
          if (branch_taken) begin
            if (FLUSH_LAT > 1) begin
              state_q <= FLUSH;
              rem_q   <= FL_REM;
            end
          end else if (hazard) begin
            if (MEM_LAT > 1) begin
              state_q <= STALL;
              rem_q   <= MEM_REM;
            end
          end
        end
        STALL, FLUSH: begin
          rem_q <= rem_q - 3'd1;
          if (rem_q == 3'd1)
            state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          rem_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: a behavioural model pushes
// expected outputs per cycle, popped and compared at the falling edge.
module tb_hazard_stall_ctrl;

  localparam int ML = 2;
  localparam int FL = 2;

  typedef struct {
    logic        stall;
    logic        flush;
    logic        bubble;
    logic        pcwe;
    logic        ifwe;
    logic        busy;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  id_rs1 = '0;
  logic [2:0]  id_rs2 = '0;
  logic        id_use_rs1 = 1'b0;
  logic        id_use_rs2 = 1'b0;
  logic [2:0]  ex_rd = '0;
  logic        ex_mem_read = 1'b0;
  logic        branch_taken = 1'b0;

  logic        stall, pc_write_en, ifid_write_en;
  logic        ifid_flush, idex_bubble, busy;
  logic [15:0] stall_count;

  logic        s_stall, s_pcwe, s_ifwe, s_flush, s_bub, s_busy;
  logic [2:0]  s_cnt;

  int n_vec = 0;
  int n_err = 0;

  exp_t q[$];

  int m_st  = 0;
  int m_rem = 0;
  int m_cnt = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(
    .REG_W(3), .MEM_LAT(ML), .FLUSH_LAT(FL), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .branch_taken(branch_taken),
    .stall(stall), .pc_write_en(pc_write_en),
    .ifid_write_en(ifid_write_en), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .busy(busy),
    .stall_count(stall_count)
  );

  hazard_stall_ctrl #(
    .REG_W(3), .MEM_LAT(2), .FLUSH_LAT(1), .CNT_W(3)
  ) dut_s (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .branch_taken(branch_taken),
    .stall(s_stall), .pc_write_en(s_pcwe),
    .ifid_write_en(s_ifwe), .ifid_flush(s_flush),
    .idex_bubble(s_bub), .busy(s_busy),
    .stall_count(s_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply(input logic rn,
                       input logic [2:0] r1, input logic [2:0] r2,
                       input logic u1, input logic u2,
                       input logic [2:0] rd, input logic mr,
                       input logic br);
    exp_t e;
    exp_t g;
    logic haz;
    @(posedge clk);
    #1;
    rst_n = rn; id_rs1 = r1; id_rs2 = r2;
    id_use_rs1 = u1; id_use_rs2 = u2;
    ex_rd = rd; ex_mem_read = mr; branch_taken = br;
    haz = mr && rd != 0 && ((u1 && r1 == rd) || (u2 && r2 == rd));
    e.stall = 0; e.flush = 0; e.busy = (m_st != 0);
    e.cnt = 16'(m_cnt);
    if (!rn) begin
      e.busy = 0; e.cnt = 0;
      m_st = 0; m_rem = 0; m_cnt = 0;
    end else begin
      case (m_st)
        0: if (br) begin
             e.flush = 1;
             if (FL > 1) begin m_st = 2; m_rem = FL - 1; end
           end else if (haz) begin
             e.stall = 1;
             if (ML > 1) begin m_st = 1; m_rem = ML - 1; end
           end
        1: begin
             e.stall = 1;
             if (m_rem == 1) m_st = 0;
             m_rem--;
           end
        default: begin
             e.flush = 1;
             if (m_rem == 1) m_st = 0;
             m_rem--;
           end
      endcase
      if (e.stall && m_cnt < 65535) m_cnt++;
    end
    e.bubble = e.stall | e.flush;
    e.pcwe = ~e.stall;
    e.ifwe = ~e.stall;
    q.push_back(e);
    @(negedge clk);
    g = q.pop_front();
    chk("stall", {31'd0, stall}, {31'd0, g.stall});
    chk("pc_we", {31'd0, pc_write_en}, {31'd0, g.pcwe});
    chk("ifid_we", {31'd0, ifid_write_en}, {31'd0, g.ifwe});
    chk("flush", {31'd0, ifid_flush}, {31'd0, g.flush});
    chk("bubble", {31'd0, idex_bubble}, {31'd0, g.bubble});
    chk("busy", {31'd0, busy}, {31'd0, g.busy});
    chk("count", {16'd0, stall_count}, {16'd0, g.cnt});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      apply(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // reset, then idle
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    apply(0, 3, 3, 1, 1, 3, 1, 0);
    idle(5);
    chk("cnt_idle", {16'd0, stall_count}, 32'd0);

    // single load-use on rs1
    apply(1, 3, 0, 1, 0, 3, 1, 0);
    chk("haz_busy0", {31'd0, busy}, 32'd0);
    idle(1);
    chk("haz_busy1", {31'd0, busy}, 32'd1);
    idle(2);
    chk("cnt_two", {16'd0, stall_count}, 32'd2);

    // no hazard: rd=0, use off, not a load
    apply(1, 0, 0, 1, 0, 0, 1, 0);
    apply(1, 3, 0, 0, 0, 3, 1, 0);
    apply(1, 5, 5, 1, 1, 5, 0, 0);
    apply(1, 2, 4, 1, 0, 4, 1, 0);
    idle(1);
    chk("cnt_nohaz", {16'd0, stall_count}, 32'd2);

    // hazard on rs2
    apply(1, 1, 6, 1, 1, 6, 1, 0);
    idle(3);
    chk("cnt_rs2", {16'd0, stall_count}, 32'd4);

    // branch beats hazard, two flush cycles
    apply(1, 3, 0, 1, 0, 3, 1, 1);
    chk("br_flush0", {31'd0, ifid_flush}, 32'd1);
    idle(1);
    chk("br_flush1", {31'd0, ifid_flush}, 32'd1);
    idle(2);
    chk("cnt_br", {16'd0, stall_count}, 32'd4);

    // reset in the first STALL cycle with hazard held
    apply(1, 3, 0, 1, 0, 3, 1, 0);
    apply(0, 3, 0, 1, 0, 3, 1, 0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_pcwe", {31'd0, pc_write_en}, 32'd1);
    idle(1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cnt", {16'd0, stall_count}, 32'd0);

    // continuous hazard for 10 cycles
    for (int i = 0; i < 10; i++)
      apply(1, 2, 0, 1, 0, 2, 1, 0);
    idle(1);
    chk("cnt_ten", {16'd0, stall_count}, 32'd10);
    chk("sat_cnt", {29'd0, s_cnt}, 32'd7);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
